// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-control inputs and PC/RAS status outputs of pc_gen
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            hold;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vect;
  logic            redir_valid;
  logic [XLEN-1:0] redir_vect;
  logic            call_push;
  logic            ret_pop;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misalign_err;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output hold, trap_valid, trap_vect, redir_valid, redir_vect, call_push, ret_pop,
    input  pc, pc_valid, misalign_err, ras_empty, ras_full
  );

  modport slave (
    input  hold, trap_valid, trap_vect, redir_valid, redir_vect, call_push, ret_pop,
    output pc, pc_valid, misalign_err, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC generator: step, stall, redirect, trap, RAS return prediction
// Misaligned redirect/return targets park the FSM in FAULT until a trap is taken.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next, seq_pc, trap_pc, ras_top;
  logic [PW:0]     count, count_next;
  logic [PW-1:0]   ptr, ptr_next, top_idx, ras_widx;
  logic            ras_we, pop_ok, valid_q, err_q;
  logic [XLEN-1:0] ras [RAS_DEPTH];

  assign seq_pc  = pc_q + XLEN'(INC);
  assign trap_pc = bus.trap_vect & ~XLEN'(3);
  assign top_idx = ptr - PW'(1);
  assign ras_top = ras[top_idx];
  assign pop_ok  = bus.ret_pop && (count != '0);

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = valid_q;
  assign bus.misalign_err = err_q;
  assign bus.ras_empty    = (count == '0);
  assign bus.ras_full     = (count == (PW+1)'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    count_next = count;
    ptr_next   = ptr;
    ras_we     = 1'b0;
    ras_widx   = ptr;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (bus.trap_valid) begin
          pc_next    = trap_pc;
          count_next = '0;
        end else if (bus.redir_valid) begin
          if (|bus.redir_vect[1:0]) state_next = FAULT;
          else                      pc_next    = bus.redir_vect;
        end else if (!bus.hold) begin
          if (pop_ok) begin
            if (|ras_top[1:0]) state_next = FAULT;
            else               pc_next    = ras_top;
          end else begin
            pc_next = seq_pc;
          end
          // Push+pop replaces the top in place; a push when full wraps onto the oldest slot.
          if (bus.call_push && pop_ok) begin
            ras_we   = 1'b1;
            ras_widx = top_idx;
          end else if (bus.call_push) begin
            ras_we   = 1'b1;
            ptr_next = ptr + PW'(1);
            if (count != (PW+1)'(RAS_DEPTH)) count_next = count + 1'b1;
          end else if (pop_ok) begin
            ptr_next   = top_idx;
            count_next = count - 1'b1;
          end
        end
      end
      FAULT: begin
        if (bus.trap_valid) begin
          pc_next    = trap_pc;
          count_next = '0;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      count   <= '0;
      ptr     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      count   <= count_next;
      ptr     <= ptr_next;
      valid_q <= (state_next == RUN);
      err_q   <= (state_next == FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ras_we) ras[ras_widx] <= seq_pc;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.hold = 0; bus.trap_valid = 0; bus.trap_vect = '0; bus.redir_valid = 0;
    bus.redir_vect = '0; bus.call_push = 0; bus.ret_pop = 0;
  endtask

  task automatic redir(input logic [31:0] v);
    idle(); bus.redir_valid = 1; bus.redir_vect = v; tick(); idle();
  endtask

  task automatic test_reset;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    idle(); rst_n = 0; tick(); tick();
    if (bus.pc !== 32'h0) begin $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); n_fail++; end n_tests++;
    if (bus.pc_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", bus.pc_valid); n_fail++; end n_tests++;
    if (bus.misalign_err !== 1'b0) begin $display("FAIL reset_err got %b exp 0", bus.misalign_err); n_fail++; end n_tests++;
    if ({bus.ras_empty, bus.ras_full} !== 2'b10) begin $display("FAIL reset_ras got %b exp 10", {bus.ras_empty, bus.ras_full}); n_fail++; end n_tests++;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.pc !== exp_pc[i]) begin $display("FAIL boot_pc[%0d] got %h exp %h", i, bus.pc, exp_pc[i]); n_fail++; end n_tests++;
      if (bus.pc_valid !== 1'b1) begin $display("FAIL boot_valid[%0d] got %b exp 1", i, bus.pc_valid); n_fail++; end n_tests++;
    end
  endtask

  task automatic test_hold_redir;
    redir(32'h10);
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.pc !== 32'h10) begin $display("FAIL hold_pc[%0d] got %h exp %h", i, bus.pc, 32'h10); n_fail++; end n_tests++;
    end
    bus.redir_valid = 1; bus.redir_vect = 32'h100; tick(); idle();
    if (bus.pc !== 32'h100) begin $display("FAIL hold_redir got %h exp %h", bus.pc, 32'h100); n_fail++; end n_tests++;
  endtask

  task automatic test_call_ret;
    redir(32'h20); bus.call_push = 1; tick(); idle();
    redir(32'h40); bus.call_push = 1; tick(); idle();
    redir(32'h80); bus.ret_pop = 1; tick();
    if (bus.pc !== 32'h44) begin $display("FAIL ret1 got %h exp %h", bus.pc, 32'h44); n_fail++; end n_tests++;
    if (bus.ras_empty !== 1'b0) begin $display("FAIL ret1_empty got %b exp 0", bus.ras_empty); n_fail++; end n_tests++;
    tick(); idle();
    if (bus.pc !== 32'h24) begin $display("FAIL ret2 got %h exp %h", bus.pc, 32'h24); n_fail++; end n_tests++;
    if (bus.ras_empty !== 1'b1) begin $display("FAIL ret2_empty got %b exp 1", bus.ras_empty); n_fail++; end n_tests++;
  endtask

  task automatic test_ras_overflow;
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h1014; exp_pc[1] = 32'h1010; exp_pc[2] = 32'h100c;
    exp_pc[3] = 32'h1008; exp_pc[4] = 32'h100c;
    redir(32'h1000);
    bus.call_push = 1;
    for (int i = 0; i < 5; i++) tick();
    idle();
    if (bus.ras_full !== 1'b1) begin $display("FAIL ovf_full got %b exp 1", bus.ras_full); n_fail++; end n_tests++;
    if (bus.pc !== 32'h1014) begin $display("FAIL ovf_pc got %h exp %h", bus.pc, 32'h1014); n_fail++; end n_tests++;
    redir(32'h5000);
    bus.ret_pop = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.pc !== exp_pc[i]) begin $display("FAIL ovf_pop[%0d] got %h exp %h", i, bus.pc, exp_pc[i]); n_fail++; end n_tests++;
    end
    idle();
    if (bus.ras_empty !== 1'b1) begin $display("FAIL ovf_empty got %b exp 1", bus.ras_empty); n_fail++; end n_tests++;
  endtask

  task automatic test_push_pop_same;
    redir(32'h300); bus.call_push = 1; tick(); idle();
    redir(32'h400); bus.call_push = 1; bus.ret_pop = 1; tick(); idle();
    if (bus.pc !== 32'h304) begin $display("FAIL pushpop_pc got %h exp %h", bus.pc, 32'h304); n_fail++; end n_tests++;
    bus.ret_pop = 1; tick(); idle();
    if (bus.pc !== 32'h404) begin $display("FAIL pushpop_top got %h exp %h", bus.pc, 32'h404); n_fail++; end n_tests++;
    if (bus.ras_empty !== 1'b1) begin $display("FAIL pushpop_empty got %b exp 1", bus.ras_empty); n_fail++; end n_tests++;
  endtask

  task automatic test_fault;
    redir(32'h600);
    redir(32'h102);
    if ({bus.pc_valid, bus.misalign_err} !== 2'b01) begin $display("FAIL fault_flags got %b exp 01", {bus.pc_valid, bus.misalign_err}); n_fail++; end n_tests++;
    if (bus.pc !== 32'h600) begin $display("FAIL fault_pc got %h exp %h", bus.pc, 32'h600); n_fail++; end n_tests++;
    bus.redir_valid = 1; bus.redir_vect = 32'h700; bus.ret_pop = 1; tick(); tick(); idle();
    if (bus.pc !== 32'h600) begin $display("FAIL fault_frozen got %h exp %h", bus.pc, 32'h600); n_fail++; end n_tests++;
    bus.trap_valid = 1; bus.trap_vect = 32'h203; tick(); idle();
    if (bus.pc !== 32'h200) begin $display("FAIL fault_trap got %h exp %h", bus.pc, 32'h200); n_fail++; end n_tests++;
    if ({bus.pc_valid, bus.misalign_err} !== 2'b10) begin $display("FAIL fault_exit got %b exp 10", {bus.pc_valid, bus.misalign_err}); n_fail++; end n_tests++;
    tick();
    if (bus.pc !== 32'h204) begin $display("FAIL fault_run got %h exp %h", bus.pc, 32'h204); n_fail++; end n_tests++;
  endtask

  task automatic test_back_to_back;
    bus.trap_valid = 1; bus.trap_vect = 32'hffff_fffc; tick(); idle(); tick();
    if (bus.pc !== 32'h0) begin $display("FAIL wrap got %h exp %h", bus.pc, 32'h0); n_fail++; end n_tests++;
    bus.call_push = 1; tick(); idle();
    bus.trap_valid = 1; bus.trap_vect = 32'h800; bus.redir_valid = 1; bus.redir_vect = 32'h900; tick(); idle();
    if (bus.pc !== 32'h800) begin $display("FAIL trap_prio got %h exp %h", bus.pc, 32'h800); n_fail++; end n_tests++;
    if (bus.ras_empty !== 1'b1) begin $display("FAIL trap_flush got %b exp 1", bus.ras_empty); n_fail++; end n_tests++;
    redir(32'h3);
    if (bus.misalign_err !== 1'b1) begin $display("FAIL pre_rst_fault got %b exp 1", bus.misalign_err); n_fail++; end n_tests++;
    rst_n = 0; tick();
    if (bus.pc !== 32'h0) begin $display("FAIL fault_rst_pc got %h exp %h", bus.pc, 32'h0); n_fail++; end n_tests++;
    if ({bus.pc_valid, bus.misalign_err} !== 2'b00) begin $display("FAIL fault_rst_flags got %b exp 00", {bus.pc_valid, bus.misalign_err}); n_fail++; end n_tests++;
    rst_n = 1; tick(); tick();
    if (bus.pc !== 32'h4) begin $display("FAIL fault_rst_run got %h exp %h", bus.pc, 32'h4); n_fail++; end n_tests++;
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_hold_redir();
    test_call_ret();
    test_ras_overflow();
    test_push_pop_same();
    test_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
